// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and helpers for the I/D memory arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_WAIT_I = 2'd1,
    ARB_WAIT_D = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_I    = 2'd1,
    OWNER_D    = 2'd2
  } arb_owner_e;

  localparam int unsigned STREAK_W = 8;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_streak_ctr.sv
// rtl/mem_arbiter_arb_streak_ctr.sv - saturating count of D grants won while I was pending
module arb_streak_ctr
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_grant,
  input  logic d_grant,
  input  logic i_req,
  output logic force_i
);

  localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] streak;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak <= '0;
    end else if (i_grant) begin
      streak <= '0;
    end else if (d_grant) begin
      if (!i_req)
        streak <= '0;
      else if (streak != MAX_S)
        streak <= streak + 1'b1;
    end
  end

  assign force_i = (streak == MAX_S);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding I/D arbiter for a shared memory port
// Optional perf counters enabled by defining MEM_ARBITER_PERF_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AWIDTH       = 32,
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [AWIDTH-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DWIDTH-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0] d_wdata,
  input  logic [1:0]        d_size,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DWIDTH-1:0] d_rdata,
`ifdef MEM_ARBITER_PERF_EN
  output logic [31:0]       perf_i_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_i_stall_cycles,
  output logic [31:0]       perf_stray_rvalid,
`endif
  output logic              mem_req,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic [1:0]        mem_size,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DWIDTH-1:0] mem_rdata
);

  arb_state_e state, state_next;
  arb_owner_e winner;
  logic       force_i;

  arb_streak_ctr #(.MAX_D_STREAK(MAX_D_STREAK)) u_streak (
    .clk     (clk),
    .reset   (reset),
    .i_grant (i_gnt),
    .d_grant (d_gnt),
    .i_req   (i_req),
    .force_i (force_i)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ARB_IDLE;
    else        state <= state_next;
  end

  // Outputs are held at 0 while reset is asserted, even with requests present.
  always_comb begin
    state_next = state;
    winner     = OWNER_NONE;
    i_gnt      = 1'b0;
    i_rvalid   = 1'b0;
    i_rdata    = '0;
    d_gnt      = 1'b0;
    d_rvalid   = 1'b0;
    d_rdata    = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_size   = '0;
    if (reset) begin
      case (state)
        ARB_IDLE: begin
          if (d_req && !(i_req && force_i)) winner = OWNER_D;
          else if (i_req)                   winner = OWNER_I;
          if (winner == OWNER_D) begin
            mem_req   = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_size  = d_size;
            if (mem_gnt) begin
              d_gnt      = 1'b1;
              state_next = ARB_WAIT_D;
            end
          end else if (winner == OWNER_I) begin
            mem_req  = 1'b1;
            mem_addr = i_addr;
            mem_size = MEM_WORD;
            if (mem_gnt) begin
              i_gnt      = 1'b1;
              state_next = ARB_WAIT_I;
            end
          end
        end
        ARB_WAIT_I: begin
          if (mem_rvalid) begin
            i_rvalid   = 1'b1;
            i_rdata    = mem_rdata;
            state_next = ARB_IDLE;
          end
        end
        ARB_WAIT_D: begin
          if (mem_rvalid) begin
            d_rvalid   = 1'b1;
            d_rdata    = mem_rdata;
            state_next = ARB_IDLE;
          end
        end
        default: state_next = ARB_IDLE;
      endcase
    end
  end

`ifdef MEM_ARBITER_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_i_grants       <= '0;
      perf_d_grants       <= '0;
      perf_i_stall_cycles <= '0;
      perf_stray_rvalid   <= '0;
    end else begin
      if (i_gnt)           perf_i_grants       <= sat_inc32(perf_i_grants);
      if (d_gnt)           perf_d_grants       <= sat_inc32(perf_d_grants);
      if (i_req && !i_gnt) perf_i_stall_cycles <= sat_inc32(perf_i_stall_cycles);
      if (state == ARB_IDLE && mem_rvalid)
        perf_stray_rvalid <= sat_inc32(perf_stray_rvalid);
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [1:0]  d_size = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
`ifdef MEM_ARBITER_PERF_EN
  logic [31:0] perf_i_grants, perf_d_grants, perf_i_stall_cycles, perf_stray_rvalid;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AWIDTH(32), .DWIDTH(32), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
`ifdef MEM_ARBITER_PERF_EN
    .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
    .perf_i_stall_cycles(perf_i_stall_cycles), .perf_stray_rvalid(perf_stray_rvalid),
`endif
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({i_gnt, d_gnt, i_rvalid, d_rvalid, mem_req, mem_we} !== 6'b0)
      $display("FAIL reset_ctrl: got %b expected 000000", {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_req, mem_we}); else passes++;
    checks++; if ({mem_addr, mem_wdata, mem_size, i_rdata, d_rdata} !== '0)
      $display("FAIL reset_data: got %h/%h/%h expected 0", mem_addr, mem_wdata, mem_size); else passes++;
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic test_fetch_only;
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h0100_0000; mem_gnt = 1'b1;
    @(negedge clk);
    checks++; if (i_gnt !== 1'b1) $display("FAIL fetch_gnt: got %b expected 1", i_gnt); else passes++;
    checks++; if (mem_addr !== 32'h0100_0000 || mem_we !== 1'b0 || mem_req !== 1'b1)
      $display("FAIL fetch_mem: got %h/%b/%b expected 01000000/0/1", mem_addr, mem_we, mem_req); else passes++;
    @(posedge clk); #1 i_req = 1'b0;
    @(negedge clk);
    checks++; if ({i_gnt, i_rvalid, mem_req} !== 3'b0)
      $display("FAIL fetch_wait: got %b expected 000", {i_gnt, i_rvalid, mem_req}); else passes++;
    @(posedge clk); #1 mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
    @(negedge clk);
    checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h13)
      $display("FAIL fetch_resp: got %b/%h expected 1/00000013", i_rvalid, i_rdata); else passes++;
    checks++; if ({d_gnt, d_rvalid} !== 2'b0 || d_rdata !== 32'h0)
      $display("FAIL fetch_d_quiet: got %b/%h expected 00/0", {d_gnt, d_rvalid}, d_rdata); else passes++;
    @(posedge clk); #1 mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_simultaneous;
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h0000_0100;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0100_0040; d_wdata = 32'hDEAD_BEEF; d_size = 2'd2;
    mem_gnt = 1'b1;
    @(negedge clk);
    checks++; if (d_gnt !== 1'b1 || i_gnt !== 1'b0)
      $display("FAIL simul_winner: got d=%b i=%b expected d=1 i=0", d_gnt, i_gnt); else passes++;
    checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h0100_0040 || mem_size !== 2'd2)
      $display("FAIL simul_fwd: got %b/%h/%h/%h expected 1/deadbeef/01000040/2", mem_we, mem_wdata, mem_addr, mem_size); else passes++;
    @(posedge clk); #1 d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    checks++; if (i_gnt !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL simul_busy: got %b/%b expected 0/0", i_gnt, mem_req); else passes++;
    @(posedge clk); #1 mem_rvalid = 1'b1; mem_rdata = '0;
    @(negedge clk);
    checks++; if (d_rvalid !== 1'b1 || i_gnt !== 1'b0 || i_rvalid !== 1'b0)
      $display("FAIL simul_dresp: got %b/%b/%b expected 1/0/0", d_rvalid, i_gnt, i_rvalid); else passes++;
    @(posedge clk); #1 mem_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (i_gnt !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0)
      $display("FAIL simul_igrant: got %b/%h/%b expected 1/00000100/0", i_gnt, mem_addr, mem_we); else passes++;
    @(posedge clk); #1 i_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55;
    @(negedge clk);
    checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h55)
      $display("FAIL simul_iresp: got %b/%h expected 1/00000055", i_rvalid, i_rdata); else passes++;
    @(posedge clk); #1 mem_rvalid = 1'b0;
  endtask

  task automatic test_streak;
    string order;
    string exp_order;
    order = "";
    exp_order = "DDDDIDDDDI";
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h0000_0200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300; d_size = 2'd2; mem_gnt = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (d_gnt === 1'b1 && i_gnt !== 1'b1) order = {order, "D"};
      else if (i_gnt === 1'b1 && d_gnt !== 1'b1) order = {order, "I"};
      else order = {order, "?"};
      @(posedge clk); #1 mem_rvalid = 1'b1; mem_rdata = k;
      @(negedge clk);
      checks++; if ((i_gnt | d_gnt) !== 1'b0 || (i_rvalid | d_rvalid) !== 1'b1)
        $display("FAIL streak_resp%0d: got gnt=%b rv=%b expected gnt=0 rv=1", k, i_gnt | d_gnt, i_rvalid | d_rvalid); else passes++;
      @(posedge clk); #1 mem_rvalid = 1'b0;
    end
    checks++; if (order != exp_order)
      $display("FAIL streak_order: got %s expected %s", order, exp_order); else passes++;
    i_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_mem_stall;
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h0000_0A00; mem_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (i_gnt !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h0A00)
        $display("FAIL stall_c%0d: got %b/%b/%h expected 0/1/00000a00", k, i_gnt, mem_req, mem_addr); else passes++;
      @(posedge clk); #1;
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    checks++; if (i_gnt !== 1'b1) $display("FAIL stall_gnt: got %b expected 1", i_gnt); else passes++;
    @(posedge clk); #1 i_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77;
    @(negedge clk);
    checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h77)
      $display("FAIL stall_resp: got %b/%h expected 1/00000077", i_rvalid, i_rdata); else passes++;
    @(posedge clk); #1 mem_rvalid = 1'b0;
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300; mem_gnt = 1'b1;
    @(negedge clk);
    checks++; if (d_gnt !== 1'b1) $display("FAIL rmid_gnt: got %b expected 1", d_gnt); else passes++;
    @(posedge clk); #1 d_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; i_req = 1'b1; d_req = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hAA;
    @(negedge clk);
    checks++; if ({i_gnt, d_gnt, i_rvalid, d_rvalid, mem_req, mem_we} !== 6'b0 || {mem_addr, mem_wdata, mem_size} !== '0)
      $display("FAIL rmid_in_reset: got %b/%h expected 000000/0", {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_req, mem_we}, mem_addr); else passes++;
    @(posedge clk); #1;
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    checks++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || d_rdata !== 32'h0)
      $display("FAIL rmid_stray: got %b/%b/%h expected 0/0/0", i_rvalid, d_rvalid, d_rdata); else passes++;
    @(posedge clk); #1 mem_rvalid = 1'b0; i_req = 1'b1; i_addr = 32'h0000_0400;
    @(negedge clk);
    checks++; if (i_gnt !== 1'b1) $display("FAIL rmid_idle: got %b expected 1", i_gnt); else passes++;
    @(posedge clk); #1 i_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h99;
    @(negedge clk);
    checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h99)
      $display("FAIL rmid_resp: got %b/%h expected 1/00000099", i_rvalid, i_rdata); else passes++;
    @(posedge clk); #1 mem_rvalid = 1'b0;
  endtask

  // Reference: one outstanding access, D preferred unless I has lost MAXS D grants in a row.
  task automatic test_random;
    int busy;
    int d_wins;
    int wait_c;
    int winner;
    logic e_ig, e_dg, e_irv, e_drv;
    logic drop_i, drop_d;
    busy = 0; d_wins = 0; wait_c = 0; drop_i = 1'b0; drop_d = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (drop_i) i_req = 1'b0;
      if (drop_d) d_req = 1'b0;
      if (!i_req && $urandom_range(0, 2) != 0) begin
        i_req = 1'b1; i_addr = $urandom;
      end
      if (!d_req && $urandom_range(0, 1) == 1) begin
        d_req = 1'b1; d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
        d_size = 2'($urandom_range(0, 2));
      end
      mem_gnt    = ($urandom_range(0, 3) != 0);
      mem_rvalid = (busy != 0 && wait_c == 0);
      mem_rdata  = $urandom;
      @(negedge clk);
      winner = 0;
      if (busy == 0) begin
        if (d_req && !(i_req && d_wins >= MAXS)) winner = 2;
        else if (i_req) winner = 1;
      end
      e_ig  = (winner == 1) && mem_gnt;
      e_dg  = (winner == 2) && mem_gnt;
      e_irv = (busy == 1) && mem_rvalid;
      e_drv = (busy == 2) && mem_rvalid;
      checks++; if (i_gnt !== e_ig || d_gnt !== e_dg || mem_req !== (winner != 0))
        $display("FAIL rnd_gnt c%0d: got i=%b d=%b req=%b expected i=%b d=%b req=%b", cyc, i_gnt, d_gnt, mem_req, e_ig, e_dg, winner != 0); else passes++;
      checks++; if (i_rvalid !== e_irv || d_rvalid !== e_drv)
        $display("FAIL rnd_rvalid c%0d: got i=%b d=%b expected i=%b d=%b", cyc, i_rvalid, d_rvalid, e_irv, e_drv); else passes++;
      checks++; if (i_rdata !== (e_irv ? mem_rdata : 32'h0) || d_rdata !== (e_drv ? mem_rdata : 32'h0))
        $display("FAIL rnd_rdata c%0d: got i=%h d=%h", cyc, i_rdata, d_rdata); else passes++;
      if (winner == 1) begin
        checks++; if (mem_addr !== i_addr || mem_we !== 1'b0)
          $display("FAIL rnd_ifwd c%0d: got %h/%b expected %h/0", cyc, mem_addr, mem_we, i_addr); else passes++;
      end else if (winner == 2) begin
        checks++; if (mem_addr !== d_addr || mem_we !== d_we || mem_wdata !== d_wdata || mem_size !== d_size)
          $display("FAIL rnd_dfwd c%0d: got %h/%b/%h/%h expected %h/%b/%h/%h", cyc, mem_addr, mem_we, mem_wdata, mem_size, d_addr, d_we, d_wdata, d_size); else passes++;
      end
      drop_i = e_ig;
      drop_d = e_dg;
      if (busy != 0) begin
        if (mem_rvalid) busy = 0;
        else wait_c--;
      end else if (e_ig || e_dg) begin
        busy   = winner;
        wait_c = $urandom_range(0, 2);
        if (e_ig) d_wins = 0;
        else if (i_req) d_wins = (d_wins < MAXS) ? d_wins + 1 : MAXS;
        else d_wins = 0;
      end
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = (busy != 0);
    @(posedge clk); #1 mem_rvalid = 1'b0;
  endtask

`ifdef MEM_ARBITER_PERF_EN
  task automatic test_perf;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 mem_rvalid = 1'b1;
    @(posedge clk); #1 mem_rvalid = 1'b0; mem_gnt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) d_req = 1'b1; else i_req = 1'b1;
      @(posedge clk); #1 d_req = 1'b0; i_req = 1'b0;
      @(posedge clk); #1 mem_rvalid = 1'b1;
      @(posedge clk); #1 mem_rvalid = 1'b0;
    end
    @(negedge clk);
    checks++; if (perf_stray_rvalid !== 32'd1)
      $display("FAIL perf_stray: got %0d expected 1", perf_stray_rvalid); else passes++;
    checks++; if (perf_d_grants !== 32'd3 || perf_i_grants !== 32'd2)
      $display("FAIL perf_grants: got d=%0d i=%0d expected d=3 i=2", perf_d_grants, perf_i_grants); else passes++;
    checks++; if (perf_i_stall_cycles !== 32'd0)
      $display("FAIL perf_stall: got %0d expected 0", perf_i_stall_cycles); else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_streak();
    test_mem_stall();
    test_reset_mid();
    test_random();
`ifdef MEM_ARBITER_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
